memoria_operandos: RTL
======================

Name: memoria_operandos

Overview:
- Parametrised dual-read, single-write operand memory. It is the next generation of the fixed 8x32 operand ROMs that feed the ALU.
- Read ports A and B supply ALU operands a and b with registered 1-cycle latency. The write port lets the datapath update operands at run time.
- A hardware init sequencer loads the power-up contents after reset or on a soft clear: word 0 = 1, all other words = 0.
- Out-of-range accesses and accesses made while busy are flagged.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 8, number of words; any value >= 2, power of two not required.
- AW, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- clk_i  input  1  clock, all state changes on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- clear_i  input  1  soft clear; re-runs the init sequence.
- we_i  input  1  write enable.
- waddr_i  input  AW  write address.
- wdata_i  input  WIDTH  write data.
- re_a_i  input  1  port A read request.
- raddr_a_i  input  AW  port A address.
- re_b_i  input  1  port B read request.
- raddr_b_i  input  AW  port B address.
- operador_a_o  output  WIDTH  port A read data (registered).
- valid_a_o  output  1  port A data valid, 1-cycle pulse.
- operador_b_o  output  WIDTH  port B read data (registered).
- valid_b_o  output  1  port B data valid, 1-cycle pulse.
- busy_o  output  1  init sequence in progress.
- err_o  output  1  1-cycle pulse on a rejected access.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: operador_a_o = operador_b_o = 0, valid_a_o = valid_b_o = 0, err_o = 0, busy_o = 1, state = INIT, init counter = 0.
- The memory array itself is not reset. The INIT sequence writes it.
- State INIT:
  - Each cycle writes mem[cnt] = (cnt==0) ? 1 : 0, then cnt++.
  - After the cycle that writes cnt == DEPTH-1, go to RUN. busy_o deasserts in the same edge.
  - INIT lasts exactly DEPTH cycles after reset release.
- State RUN:
  - Write: we_i=1 and waddr_i < DEPTH -> mem[waddr_i] <= wdata_i at the edge.
  - Read A: re_a_i=1 and raddr_a_i < DEPTH -> next cycle operador_a_o = mem[raddr_a_i] and valid_a_o = 1.
  - Read B: same as read A, independent port.
  - Holding: operador_*_o holds its last value when there is no read. valid_*_o is 0 in any cycle without an accepted read on the previous edge.
  - Both ports may read the same address in the same cycle; both return the same data.
- clear_i = 1 in RUN: go to INIT next edge, cnt = 0, busy_o = 1. Any write or read in that cycle is rejected.
- clear_i during INIT: restart cnt at 0.
- Rejection:
  - Any we_i or re_*_i while busy_o = 1 is ignored and pulses err_o next cycle.
  - Any address >= DEPTH on an asserted enable is ignored and pulses err_o next cycle. No memory change; valid is not raised for that port.
  - err_o is a single OR of all rejection causes.
- Read/write same address, same cycle, without bypass: the read returns the old data. The write takes effect for reads issued on later cycles.
- Reset mid-operation: returns to INIT immediately. Pending valid pulses are cleared.

Optional Feature:
- Macro MEM_BYPASS_EN.
- Defined: in RUN, a read whose address equals the same-cycle accepted write address returns wdata_i (write-first forwarding), per port independently.
- Not defined: read-first behaviour as described above.

Test Plan:
- Reset release, DEPTH=8 -> busy_o=1 for exactly 8 cycles. Then read A addr 0 and read B addr 5 -> next cycle operador_a_o=1, operador_b_o=0, both valids=1 for one cycle.
- Write 0xA7264A45 to addr 1, next cycle read A addr 1 -> operador_a_o=0xA7264A45, valid_a_o=1, err_o=0.
- Same-cycle write 0x12345678 to addr 2 with read B addr 2 -> without MEM_BYPASS_EN operador_b_o=0. With MEM_BYPASS_EN operador_b_o=0x12345678.
- DEPTH=6, read A addr 7 -> valid_a_o=0, err_o pulses one cycle, operador_a_o unchanged. Write request during busy -> err_o pulse, and after init, addr 0 still reads 1.
- Write 0xFFFFFFFF to addr 3, assert clear_i one cycle -> busy_o=1 for 8 cycles, then read addr 3 -> 0 and read addr 0 -> 1.
- Assert rst_ni=0 mid-INIT (cnt=4) -> outputs zero asynchronously. After release, busy_o=1 for a full 8 cycles.

Source files
------------

// File: rtl/memoria_operandos.sv
// Dual-read, single-write operand memory with a hardware init sequencer.
// Optional write-first forwarding on the read ports: define MEM_BYPASS_EN.
module memoria_operandos #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_a_i,
    input  logic [AW-1:0]    raddr_a_i,
    input  logic             re_b_i,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] operador_a_o,
    output logic             valid_a_o,
    output logic [WIDTH-1:0] operador_b_o,
    output logic             valid_b_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             valid_a_q, valid_a_d;
    logic             valid_b_q, valid_b_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic waddr_ok, raddr_a_ok, raddr_b_ok;
    logic any_req;

    assign waddr_ok   = {1'b0, waddr_i}   < DEPTH_W;
    assign raddr_a_ok = {1'b0, raddr_a_i} < DEPTH_W;
    assign raddr_b_ok = {1'b0, raddr_b_i} < DEPTH_W;
    assign any_req    = we_i | re_a_i | re_b_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        valid_a_d = 1'b0;
        valid_b_d = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;

        unique case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = (cnt_q == '0) ? WIDTH'(1) : '0;
                err_d     = any_req;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            RUN: begin
                if (clear_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    err_d   = any_req;
                end else begin
                    err_d = (we_i & ~waddr_ok)
                          | (re_a_i & ~raddr_a_ok)
                          | (re_b_i & ~raddr_b_ok);
                    if (we_i && waddr_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = waddr_i;
                        mem_wdata = wdata_i;
                    end
                    if (re_a_i && raddr_a_ok) begin
                        valid_a_d = 1'b1;
                        op_a_d    = mem_q[raddr_a_i];
`ifdef MEM_BYPASS_EN
                        if (we_i && waddr_ok && waddr_i == raddr_a_i)
                            op_a_d = wdata_i;
`endif
                    end
                    if (re_b_i && raddr_b_ok) begin
                        valid_b_d = 1'b1;
                        op_b_d    = mem_q[raddr_b_i];
`ifdef MEM_BYPASS_EN
                        if (we_i && waddr_ok && waddr_i == raddr_b_i)
                            op_b_d = wdata_i;
`endif
                    end
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
            err_q     <= err_d;
        end
    end

    // Storage has no reset; contents come from the init sequencer.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign operador_a_o = op_a_q;
    assign operador_b_o = op_b_q;
    assign valid_a_o    = valid_a_q;
    assign valid_b_o    = valid_b_q;
    assign err_o        = err_q;
    assign busy_o       = (state_q == INIT);

endmodule
